// File: rtl/dff_mem_burst.sv
// dff_mem_burst: parametrised DFF-based RAM behind a valid/ready command port.
// Each command starts a write or read burst of cmd_len+1 beats at cmd_addr.
// The address auto-increments and wraps modulo DEPTH.
// Read beats are registered and held under backpressure from rd_ready.
// Optional feature macro: DFF_MEM_PARITY_EN.
//   When defined, each word carries an even-parity bit, par_flip corrupts it
//   on write, and rd_err reports a mismatch. Otherwise rd_err is tied low.
module dff_mem_burst #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
`ifdef DFF_MEM_PARITY_EN
  input  logic             par_flip,
`endif
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_err,
  output logic             busy
);

`ifdef DFF_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    addr;
  logic [LEN_W-1:0] cnt;
  logic [MW-1:0]    mem [DEPTH];
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    rd_word;
  logic             cmd_fire;
  logic             wr_fire;
  logic             rd_issue;
  logic             last_beat;

`ifdef DFF_MEM_PARITY_EN
  logic rd_err_q;
  assign wr_word = {(^wr_data) ^ par_flip, wr_data};
  assign rd_err  = rd_err_q;
`else
  assign wr_word = wr_data;
  assign rd_err  = 1'b0;
`endif

  assign rd_word   = mem[addr];
  assign last_beat = (cnt == '0);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_issue  = (state == READ) && (!rd_valid || rd_ready);
  assign busy      = (state != IDLE) || rd_valid;

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; a command waits until any held read beat drains.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rd_valid;
        if (cmd_valid && !rd_valid) begin
          state_next = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && last_beat) begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (rd_issue && last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst address/count and the registered read beat, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (cmd_fire) begin
        addr <= cmd_addr;
        cnt  <= cmd_len;
      end else if (wr_fire || rd_issue) begin
        addr <= addr + AW'(1);
        if (!last_beat) begin
          cnt <= cnt - LEN_W'(1);
        end
      end
      if (rd_issue) begin
        rd_valid <= 1'b1;
        rd_data  <= rd_word[WIDTH-1:0];
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

`ifdef DFF_MEM_PARITY_EN
  // Parity check result travels with the read beat it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err_q <= 1'b0;
    end else if (rd_issue) begin
      rd_err_q <= rd_word[WIDTH] != (^rd_word[WIDTH-1:0]);
    end
  end
`endif

  // Storage array is deliberately not reset so it maps to plain flops.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[addr] <= wr_word;
    end
  end

endmodule

// File: tb/tb_dff_mem_burst.sv
// tb_dff_mem_burst: directed bench for dff_mem_burst with a transaction-level model.
// Define DFF_MEM_PARITY_EN for both files to exercise the parity option.
module tb_dff_mem_burst;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LEN_W = 4;
  localparam int AW    = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [AW-1:0]    cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;
  logic             busy;
`ifdef DFF_MEM_PARITY_EN
  logic             par_flip = 1'b0;
  logic             wflip [16];
`endif

  logic [WIDTH-1:0] wdat [16];
  logic [WIDTH-1:0] mem_m [DEPTH];
  logic             mem_e [DEPTH];
  beat_t            r_q [$];
  beat_t            got_q [$];
  int               w_left = 0;
  int               w_addr = 0;
  bit               r_wait = 1'b0;
  bit               m_idle;
  bit               exp_rv;
  int               vectors = 0;
  int               miscompares = 0;

  dff_mem_burst #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
`ifdef DFF_MEM_PARITY_EN
    .par_flip(par_flip),
`endif
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_err(rd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkGot(input string name, input int idx, input logic [WIDTH-1:0] data, input logic err);
    if (idx < got_q.size()) begin
      checkOutput(name, 32'(got_q[idx].data), 32'(data));
      checkOutput(name, 32'(got_q[idx].err), 32'(err));
    end else begin
      checkOutput(name, 32'hFFFF_FFFF, 32'(data));
    end
  endtask

  task automatic applyStimulus(input bit v, input bit w, input int addr, input int len);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = AW'(addr);
    cmd_len   = LEN_W'(len);
  endtask

  // Offer a command from posedge+1 until the DUT accepts it (bounded).
  task automatic send_cmd(input bit w, input int addr, input int len);
    bit acc = 1'b0;
    int t = 0;
    applyStimulus(1'b1, w, addr, len);
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    applyStimulus(1'b0, 1'b0, 0, 0);
    if (!acc) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  // Write burst: nbeats beats from wdat, with gap idle cycles between beats.
  task automatic write_burst(input int addr, input int len, input int nbeats, input int gap);
    send_cmd(1'b1, addr, len);
    for (int b = 0; b < nbeats; b++) begin
      if (b != 0) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      begin
        bit acc = 1'b0;
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = wdat[b];
`ifdef DFF_MEM_PARITY_EN
        par_flip = wflip[b];
`endif
        while (!acc && t < 50) begin
          @(negedge clk);
          acc = wr_ready;
          @(posedge clk);
          #1;
          t++;
        end
        wr_valid = 1'b0;
`ifdef DFF_MEM_PARITY_EN
        par_flip = 1'b0;
`endif
        if (!acc) checkOutput("write_timeout", 32'd0, 32'd1);
      end
    end
  endtask

  // Read burst with a repeating 4-cycle rd_ready pattern; beats land in got_q.
  task automatic read_burst(input int addr, input int len, input bit [3:0] pat);
    int k = 0;
    got_q.delete();
    rd_ready = pat[0];
    send_cmd(1'b0, addr, len);
    @(posedge clk);
    #1;
    checkOutput("first_beat_latency", 32'(rd_valid), 32'd1);
    while (got_q.size() < len + 1 && k < 200) begin
      rd_ready = pat[k % 4];
      @(negedge clk);
      @(posedge clk);
      #1;
      k++;
    end
    rd_ready = 1'b0;
    checkOutput("read_beat_count", 32'(got_q.size()), 32'(len + 1));
  endtask

  // Model: outstanding write beats, queue of expected read beats, memory image.
  // Checked at negedge, then advanced by the handshakes the next posedge will take.
  always @(negedge clk) begin
    if (rst) begin
      w_left = 0;
      r_wait = 1'b0;
      r_q.delete();
    end else begin
      m_idle = (w_left == 0) && (r_q.size() == 0);
      exp_rv = (r_q.size() > 0) && !r_wait;
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(m_idle));
      checkOutput("wr_ready", 32'(wr_ready), 32'(w_left > 0));
      checkOutput("busy", 32'(busy), 32'(!m_idle));
      checkOutput("rd_valid", 32'(rd_valid), 32'(exp_rv));
      if (exp_rv) begin
        checkOutput("rd_data", 32'(rd_data), 32'(r_q[0].data));
        checkOutput("rd_err", 32'(rd_err), 32'(r_q[0].err));
      end
      if (r_wait) begin
        r_wait = 1'b0;
      end else if (exp_rv && rd_ready) begin
        got_q.push_back('{data: rd_data, err: rd_err});
        void'(r_q.pop_front());
      end else if (w_left > 0 && wr_valid) begin
        mem_m[w_addr] = wr_data;
`ifdef DFF_MEM_PARITY_EN
        mem_e[w_addr] = par_flip;
`else
        mem_e[w_addr] = 1'b0;
`endif
        w_addr = (w_addr + 1) % DEPTH;
        w_left--;
      end else if (m_idle && cmd_valid) begin
        if (cmd_write) begin
          w_left = int'(cmd_len) + 1;
          w_addr = int'(cmd_addr);
        end else begin
          for (int i = 0; i <= int'(cmd_len); i++) begin
            r_q.push_back('{data: mem_m[(int'(cmd_addr) + i) % DEPTH],
                            err: mem_e[(int'(cmd_addr) + i) % DEPTH]});
          end
          r_wait = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      mem_e[i] = 1'b0;
    end
`ifdef DFF_MEM_PARITY_EN
    for (int i = 0; i < 16; i++) wflip[i] = 1'b0;
`endif
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload every word so later reads never see uninitialised storage.
    for (int i = 0; i < 16; i++) wdat[i] = 8'(8'h80 + i);
    write_burst(0, 15, 16, 0);
    checkOutput("model_preload", 32'(mem_m[7]), 32'h87);

    // T2: single-beat write then read.
    wdat[0] = 8'hA5;
    write_burst(3, 0, 1, 0);
    read_burst(3, 0, 4'b1111);
    checkGot("t2_data", 0, 8'hA5, 1'b0);
    checkOutput("t2_idle", 32'(cmd_ready), 32'd1);

    // T3: burst crossing the top of the address space.
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    write_burst(14, 3, 4, 0);
    read_burst(14, 3, 4'b1111);
    checkGot("t3_b0", 0, 8'h11, 1'b0);
    checkGot("t3_b1", 1, 8'h22, 1'b0);
    checkGot("t3_b2", 2, 8'h33, 1'b0);
    checkGot("t3_b3", 3, 8'h44, 1'b0);
    read_burst(0, 1, 4'b1111);
    checkGot("t3_ram0", 0, 8'h33, 1'b0);
    checkGot("t3_ram1", 1, 8'h44, 1'b0);
    checkOutput("model_ram0", 32'(mem_m[0]), 32'h33);

    // T4: read backpressure with rd_ready 1,0,0,1 repeating.
    read_burst(14, 3, 4'b1001);
    checkGot("t4_b0", 0, 8'h11, 1'b0);
    checkGot("t4_b1", 1, 8'h22, 1'b0);
    checkGot("t4_b2", 2, 8'h33, 1'b0);
    checkGot("t4_b3", 3, 8'h44, 1'b0);

    // T5: stray beats in IDLE are dropped; gapped write stores exactly 3 words.
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    wdat[0] = 8'h5A; wdat[1] = 8'h6B; wdat[2] = 8'h7C;
    write_burst(8, 2, 3, 2);
    read_burst(8, 3, 4'b1111);
    checkGot("t5_b0", 0, 8'h5A, 1'b0);
    checkGot("t5_b1", 1, 8'h6B, 1'b0);
    checkGot("t5_b2", 2, 8'h7C, 1'b0);
    checkGot("t5_untouched", 3, 8'h8B, 1'b0);

    // T1: reset in the middle of a write burst.
    wdat[0] = 8'hC1; wdat[1] = 8'hC2;
    write_burst(2, 3, 2, 0);
    rst = 1'b1;
    #1;
    checkOutput("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("t1_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("t1_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("t1_rd_data", 32'(rd_data), 32'd0);
    checkOutput("t1_rd_err", 32'(rd_err), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t1_post_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    read_burst(2, 2, 4'b1111);
    checkGot("t1_kept0", 0, 8'hC1, 1'b0);
    checkGot("t1_kept1", 1, 8'hC2, 1'b0);
    checkGot("t1_kept2", 2, 8'h84, 1'b0);

`ifdef DFF_MEM_PARITY_EN
    // T6: corrupted parity on one word flags only that beat.
    wdat[0] = 8'h0F; wflip[0] = 1'b1;
    write_burst(5, 0, 1, 0);
    wdat[0] = 8'h0F; wflip[0] = 1'b0;
    write_burst(6, 0, 1, 0);
    read_burst(5, 1, 4'b1111);
    checkGot("t6_flipped", 0, 8'h0F, 1'b1);
    checkGot("t6_clean", 1, 8'h0F, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
